led_pattern_seq: RTL and testbench

//  Parametrised LED pattern store and sequencer for board-level LED outputs.

---
 rtl/led_pattern_seq.sv | 110 +++++++++++
 tb/tb_led_pattern_seq.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: DEPTH x LED_W pattern store driving a registered LED output.
// Manual mode shows the switch-selected pattern. Auto mode steps through the
// patterns once every TICK_DIV cycles, wrapping from DEPTH-1 back to 0.
// Writes land in the store in either mode and bypass onto ld when they target
// the entry about to be displayed.
//
// Write port: wr_en is a single-cycle strobe with no back-pressure. Every cycle
// with wr_en = 1 commits wr_data to entry wr_addr on that clock edge.
module led_pattern_seq #(
  parameter int LED_W    = 8,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] switch,
  input  logic              mode,
  input  logic              hold,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LED_W-1:0]  wr_data,
  output logic [LED_W-1:0]  ld,
  output logic [ADDR_W-1:0] cur_idx,
  output logic              tick
);

  localparam int                CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [LED_W-1:0]  PAT0     = {(LED_W/4){4'b1001}};
  localparam logic [LED_W-1:0]  PAT1     = {(LED_W/4){4'b0110}};

  logic [LED_W-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_cur_idx;
  logic [LED_W-1:0]  r_ld;
  logic              r_tick;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mode_q;

  logic [ADDR_W-1:0] w_idx_n;
  logic [CNT_W-1:0]  w_cnt_n;
  logic              w_tick_n;
  logic [LED_W-1:0]  w_ld_n;

  // Next index, prescaler and tick; a rising mode edge restarts auto stepping
  // from the pattern the switches currently select.
  always_comb begin
    w_idx_n  = r_cur_idx;
    w_cnt_n  = r_cnt;
    w_tick_n = 1'b0;
    if (!mode) begin
      w_idx_n = switch;
      w_cnt_n = '0;
    end else if (!r_mode_q) begin
      w_idx_n = switch;
      w_cnt_n = '0;
    end else if (hold) begin
      w_idx_n = r_cur_idx;
      w_cnt_n = r_cnt;
    end else if (r_cnt == CNT_LAST) begin
      w_cnt_n  = '0;
      w_tick_n = 1'b1;
      w_idx_n  = (r_cur_idx == IDX_LAST) ? '0 : r_cur_idx + 1'b1;
    end else begin
      w_cnt_n = r_cnt + 1'b1;
    end
  end

  // LED data for the next cycle, with a same-cycle write taking priority.
  always_comb begin
    w_ld_n = r_mem[w_idx_n];
    if (wr_en && (wr_addr == w_idx_n)) begin
      w_ld_n = wr_data;
    end
  end

  // Pattern store: reset loads the two default patterns, all else cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (i == 0) ? PAT0 : ((i == 1) ? PAT1 : '0);
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_idx <= '0;
      r_ld      <= PAT0;
      r_tick    <= 1'b0;
      r_cnt     <= '0;
      r_mode_q  <= 1'b0;
    end else begin
      r_cur_idx <= w_idx_n;
      r_ld      <= w_ld_n;
      r_tick    <= w_tick_n;
      r_cnt     <= w_cnt_n;
      r_mode_q  <= mode;
    end
  end

  assign ld      = r_ld;
  assign cur_idx = r_cur_idx;
  assign tick    = r_tick;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Bench for led_pattern_seq with TICK_DIV = 4. A behavioural model tracks the
// displayed pattern as "cycles elapsed since the auto sequence last moved".
module tb_led_pattern_seq;

  localparam int LED_W    = 8;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int TICK_DIV = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] switch  = '0;
  logic              mode    = 1'b0;
  logic              hold    = 1'b0;
  logic              wr_en   = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [LED_W-1:0]  wr_data = '0;
  logic [LED_W-1:0]  ld;
  logic [ADDR_W-1:0] cur_idx;
  logic              tick;

  led_pattern_seq #(
    .LED_W(LED_W), .DEPTH(DEPTH), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .mode(mode), .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .ld(ld), .cur_idx(cur_idx), .tick(tick)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [LED_W-1:0] m_mem [DEPTH];
  int               m_idx;
  logic [LED_W-1:0] m_ld;
  logic             m_tick;
  int               m_phase;      // cycles spent in the current auto step
  logic             m_prev_mode;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_mem[0] = 8'h99;
    m_mem[1] = 8'h66;
    m_idx = 0; m_ld = 8'h99; m_tick = 1'b0; m_phase = 0; m_prev_mode = 1'b0;
  endtask

  // Advance model and DUT by one clock; returns at posedge + 1.
  task automatic step();
    int nidx;
    nidx   = m_idx;
    m_tick = 1'b0;
    if (!mode || !m_prev_mode) begin
      nidx = switch;
      m_phase = 0;
    end else if (!hold) begin
      m_phase = m_phase + 1;
      if (m_phase == TICK_DIV) begin
        m_phase = 0;
        m_tick  = 1'b1;
        nidx    = (m_idx + 1) % DEPTH;
      end
    end
    m_ld = (wr_en && wr_addr == nidx) ? wr_data : m_mem[nidx];
    if (wr_en) m_mem[wr_addr] = wr_data;
    m_idx = nidx;
    m_prev_mode = mode;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mode = 0; hold = 0; wr_en = 0; switch = 0;
    do_reset();
    n_checks++; if (ld !== 8'h99) begin n_fail++; $display("FAIL reset_ld got %h exp 99", ld); end
    n_checks++; if (cur_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", cur_idx); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reset_tick got %b exp 0", tick); end
  endtask

  task automatic test_manual();
    switch = 0; step();
    n_checks++; if (ld !== 8'h99) begin n_fail++; $display("FAIL manual_sw0 got %h exp 99", ld); end
    switch = 1;
    n_checks++; if (ld !== 8'h99) begin n_fail++; $display("FAIL manual_latency got %h exp 99", ld); end
    step();
    n_checks++; if (ld !== 8'h66) begin n_fail++; $display("FAIL manual_sw1 got %h exp 66", ld); end
    n_checks++; if (cur_idx !== 3'd1) begin n_fail++; $display("FAIL manual_idx1 got %0d exp 1", cur_idx); end
    switch = 5; step();
    n_checks++; if (ld !== 8'h00) begin n_fail++; $display("FAIL manual_sw5 got %h exp 00", ld); end
  endtask

  task automatic test_write_bypass();
    switch = 5; wr_en = 1; wr_addr = 5; wr_data = 8'hA5;
    step();
    wr_en = 0;
    n_checks++; if (ld !== 8'hA5) begin n_fail++; $display("FAIL bypass_ld got %h exp a5", ld); end
    n_checks++; if (cur_idx !== 3'd5) begin n_fail++; $display("FAIL bypass_idx got %0d exp 5", cur_idx); end
    step();
    n_checks++; if (ld !== m_ld) begin n_fail++; $display("FAIL bypass_stored got %h exp %h", ld, m_ld); end
  endtask

  task automatic test_auto_wrap();
    logic [ADDR_W-1:0] exp_q[$];
    int ticks;
    exp_q = {3'd6, 3'd6, 3'd6, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    switch = 6; step();
    mode = 1;
    ticks = 0;
    while (exp_q.size() > 0) begin
      logic [ADDR_W-1:0] e;
      e = exp_q.pop_front();
      step();
      if (tick === 1'b1) ticks++;
      n_checks++; if (cur_idx !== e) begin n_fail++; $display("FAIL auto_idx got %0d exp %0d", cur_idx, e); end
      n_checks++; if (tick !== m_tick) begin n_fail++; $display("FAIL auto_tick got %b exp %b", tick, m_tick); end
      n_checks++; if (ld !== m_ld) begin n_fail++; $display("FAIL auto_ld got %h exp %h", ld, m_ld); end
    end
    n_checks++; if (ticks != 3) begin n_fail++; $display("FAIL auto_tick_count got %0d exp 3", ticks); end
  endtask

  task automatic test_hold();
    logic [ADDR_W-1:0] idx0;
    logic [LED_W-1:0]  ld0;
    int waited;
    step(); // leave the step edge so hold starts mid-count
    idx0 = cur_idx; ld0 = ld;
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++; if (cur_idx !== idx0) begin n_fail++; $display("FAIL hold_idx got %0d exp %0d", cur_idx, idx0); end
      n_checks++; if (ld !== ld0) begin n_fail++; $display("FAIL hold_ld got %h exp %h", ld, ld0); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL hold_tick got %b exp 0", tick); end
    end
    hold = 0;
    waited = 0;
    while (tick !== 1'b1 && waited < 20) begin
      step();
      waited++;
    end
    // one cycle counted before hold, so TICK_DIV-1 more after release
    n_checks++; if (waited != TICK_DIV - 1) begin n_fail++; $display("FAIL hold_resume got %0d cycles exp %0d", waited, TICK_DIV - 1); end
    n_checks++; if (cur_idx !== m_idx[ADDR_W-1:0]) begin n_fail++; $display("FAIL hold_resume_idx got %0d exp %0d", cur_idx, m_idx); end
  endtask

  task automatic test_write_advance();
    bit found;
    found = 0;
    mode = 1; hold = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_prev_mode && m_idx == 0 && m_phase == TICK_DIV - 1) begin
        wr_en = 1; wr_addr = 1; wr_data = 8'h3C;
        step();
        wr_en = 0;
        found = 1;
        n_checks++; if (ld !== 8'h3C) begin n_fail++; $display("FAIL wadv_ld got %h exp 3c", ld); end
        n_checks++; if (cur_idx !== 3'd1) begin n_fail++; $display("FAIL wadv_idx got %0d exp 1", cur_idx); end
        n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL wadv_tick got %b exp 1", tick); end
      end else begin
        step();
      end
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL wadv_timeout got none exp advance to 1"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold    = ($urandom_range(0, 5) == 0);
      switch  = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
      wr_data = LED_W'($urandom);
      step();
      n_checks++; if (ld !== m_ld) begin n_fail++; $display("FAIL rand_ld cyc %0d got %h exp %h", i, ld, m_ld); end
      n_checks++; if (cur_idx !== m_idx[ADDR_W-1:0]) begin n_fail++; $display("FAIL rand_idx cyc %0d got %0d exp %0d", i, cur_idx, m_idx); end
      n_checks++; if (tick !== m_tick) begin n_fail++; $display("FAIL rand_tick cyc %0d got %b exp %b", i, tick, m_tick); end
    end
    wr_en = 0; hold = 0;
  endtask

  task automatic test_reset_mid();
    bit found;
    wr_en = 1; wr_addr = 5; wr_data = 8'h5A; step();
    wr_addr = 2; wr_data = 8'hC3; step();
    wr_en = 0;
    mode = 1; hold = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      step();
      if (m_idx == 3) found = 1;
    end
    if (!found) begin n_checks++; n_fail++; $display("FAIL rstmid_timeout got none exp idx 3"); end
    n_checks++; if (cur_idx !== 3'd3) begin n_fail++; $display("FAIL rstmid_pre_idx got %0d exp 3", cur_idx); end
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_checks++; if (ld !== 8'h99) begin n_fail++; $display("FAIL rstmid_ld got %h exp 99", ld); end
    n_checks++; if (cur_idx !== 3'd0) begin n_fail++; $display("FAIL rstmid_idx got %0d exp 0", cur_idx); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rstmid_tick got %b exp 0", tick); end
    mode = 0;
    #1;
    rst_n = 1;
    switch = 5; step();
    n_checks++; if (ld !== 8'h00) begin n_fail++; $display("FAIL rstmid_mem5 got %h exp 00", ld); end
    switch = 2; step();
    n_checks++; if (ld !== 8'h00) begin n_fail++; $display("FAIL rstmid_mem2 got %h exp 00", ld); end
    switch = 1; step();
    n_checks++; if (ld !== 8'h66) begin n_fail++; $display("FAIL rstmid_mem1 got %h exp 66", ld); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    #12;
    test_reset();
    test_manual();
    test_write_bypass();
    test_auto_wrap();
    test_hold();
    test_write_advance();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
